counter_mod_updown: RTL and testbench

//  Parametrised modulo-N up/down counter. Successor of the fixed 0..999 counter.

---
 rtl/counter_pkg.sv | 36 +++
 rtl/counter_next_calc.sv | 68 ++++++
 rtl/counter_mod_updown.sv | 74 +++++++
 tb/tb_counter_mod_updown.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the modulo up/down counter family: mode constants,
// a width helper and the per-cycle command decoded from the request inputs.
package counter_pkg;

  localparam int CNT_MODE_WRAP = 0;
  localparam int CNT_MODE_SAT  = 1;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One command per cycle, already resolved by priority.
  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_DOWN,
    CMD_UP,
    CMD_CLEAR,
    CMD_LOAD
  } cmd_e;

  // Load beats everything, up+down together is a clear, otherwise single steps.
  function automatic cmd_e decode_cmd(input logic load, input logic up, input logic down);
    if (load)
      return CMD_LOAD;
    else if (up && down)
      return CMD_CLEAR;
    else if (up)
      return CMD_UP;
    else if (down)
      return CMD_DOWN;
    else
      return CMD_HOLD;
  endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-value logic for one modulo counter field. It is kept
// separate from the register so a multi-field time counter can reuse it.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int MODULO   = 1000,
  parameter int WIDTH    = clog2_min1(MODULO),
  parameter int SATURATE = CNT_MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  cmd_e             cmd,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] next_count,
  output logic             carry,
  output logic             borrow,
  output logic             load_err
);

  // Top of the count range, one bit wider than the count so the
  // load compare and the +1 never overflow.
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH + 1)'(MODULO - 1);
  localparam bit             SAT     = (SATURATE == CNT_MODE_SAT);

  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] load_ext;
  logic [WIDTH:0] next_ext;
  logic           unused_msb;

  // Next value, boundary flags and load range check for the decoded command.
  always_comb begin
    count_ext = {1'b0, count};
    load_ext  = {1'b0, load_value};
    next_ext  = count_ext;
    carry     = 1'b0;
    borrow    = 1'b0;
    load_err  = 1'b0;
    unique case (cmd)
      CMD_LOAD: begin
        load_err = (load_ext > MAX_EXT);
        next_ext = load_err ? MAX_EXT : load_ext;
      end
      CMD_CLEAR: next_ext = '0;
      CMD_UP: begin
        if (count_ext == MAX_EXT) begin
          carry    = 1'b1;
          next_ext = SAT ? MAX_EXT : '0;
        end else if (count_ext > MAX_EXT) begin
          next_ext = '0;
        end else begin
          next_ext = count_ext + 1'b1;
        end
      end
      CMD_DOWN: begin
        if (count_ext == '0) begin
          borrow   = 1'b1;
          next_ext = SAT ? '0 : MAX_EXT;
        end else if (count_ext > MAX_EXT) begin
          next_ext = SAT ? count_ext : MAX_EXT;
        end else begin
          next_ext = count_ext - 1'b1;
        end
      end
      default: next_ext = count_ext;
    endcase
    {unused_msb, next_count} = next_ext;
  end

endmodule

// File: rtl/counter_mod_updown.sv
// Parametrised modulo-N up/down counter with wrap or saturate mode, parallel
// load, chainable carry/borrow and sticky event/load-error flags.
module counter_mod_updown
  import counter_pkg::*;
#(
  parameter int MODULO      = 1000,
  parameter int WIDTH       = clog2_min1(MODULO),
  parameter int SATURATE    = CNT_MODE_WRAP,
  parameter int RESET_VALUE = 0
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_up,
  input  logic             i_down,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_clr_flags,
  output logic [WIDTH-1:0] o_count,
  output logic             o_carryup,
  output logic             o_borrowdown,
  output logic             o_event,
  output logic             o_load_err
);

  if (MODULO < 2) begin : g_bad_modulo
    $error("counter_mod_updown: MODULO must be at least 2");
  end
  if (WIDTH < $clog2(MODULO)) begin : g_bad_width
    $error("counter_mod_updown: WIDTH too small for MODULO");
  end
  if (RESET_VALUE >= MODULO) begin : g_bad_reset
    $error("counter_mod_updown: RESET_VALUE must be below MODULO");
  end

  cmd_e             cmd;
  logic [WIDTH-1:0] next_count;
  logic             load_err_set;

  assign cmd = decode_cmd(i_load, i_up, i_down);

  counter_next_calc #(
    .MODULO   (MODULO),
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_next (
    .count      (o_count),
    .cmd        (cmd),
    .load_value (i_load_value),
    .next_count (next_count),
    .carry      (o_carryup),
    .borrow     (o_borrowdown),
    .load_err   (load_err_set)
  );

  // Count register; reset drops it straight back to the reset value.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      o_count <= WIDTH'(RESET_VALUE);
    else
      o_count <= next_count;
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_event    <= 1'b0;
      o_load_err <= 1'b0;
    end else begin
      o_event    <= (o_event & ~i_clr_flags) | o_carryup | o_borrowdown;
      o_load_err <= (o_load_err & ~i_clr_flags) | load_err_set;
    end
  end

endmodule

// File: tb/tb_counter_mod_updown.sv
// Self-checking bench: a default counter, a 60 saturating counter and a
// sec->min chain, all compared every cycle against an arithmetic model.
module tb_counter_mod_updown;

  logic clk;
  logic rstn;

  logic       a_up, a_down, a_load, a_clr;
  logic [9:0] a_lv, a_count;
  logic       a_carry, a_borrow, a_event, a_err;

  logic       s_up, s_down, s_load, s_clr;
  logic [5:0] s_lv, s_count;
  logic       s_carry, s_borrow, s_event, s_err;

  logic       sec_up, sec_down, sec_load, sec_clr;
  logic [5:0] sec_lv, sec_count;
  logic       sec_carry, sec_borrow, sec_event, sec_err;

  logic       min_down, min_load, min_clr;
  logic [5:0] min_lv, min_count;
  logic       min_carry, min_borrow, min_event, min_err;

  int ma_count, ms_count, mc_count, mm_count;
  bit ma_event, ma_err, ms_event, ms_err, mc_event, mc_err, mm_event, mm_err;

  int errors = 0;
  int checks = 0;

  counter_mod_updown u_a (
    .i_clk(clk), .i_rstn(rstn), .i_up(a_up), .i_down(a_down), .i_load(a_load),
    .i_load_value(a_lv), .i_clr_flags(a_clr), .o_count(a_count),
    .o_carryup(a_carry), .o_borrowdown(a_borrow), .o_event(a_event), .o_load_err(a_err)
  );

  counter_mod_updown #(.MODULO(60), .SATURATE(1)) u_s (
    .i_clk(clk), .i_rstn(rstn), .i_up(s_up), .i_down(s_down), .i_load(s_load),
    .i_load_value(s_lv), .i_clr_flags(s_clr), .o_count(s_count),
    .o_carryup(s_carry), .o_borrowdown(s_borrow), .o_event(s_event), .o_load_err(s_err)
  );

  counter_mod_updown #(.MODULO(60)) u_sec (
    .i_clk(clk), .i_rstn(rstn), .i_up(sec_up), .i_down(sec_down), .i_load(sec_load),
    .i_load_value(sec_lv), .i_clr_flags(sec_clr), .o_count(sec_count),
    .o_carryup(sec_carry), .o_borrowdown(sec_borrow), .o_event(sec_event), .o_load_err(sec_err)
  );

  counter_mod_updown #(.MODULO(60)) u_min (
    .i_clk(clk), .i_rstn(rstn), .i_up(sec_carry), .i_down(min_down), .i_load(min_load),
    .i_load_value(min_lv), .i_clr_flags(min_clr), .o_count(min_count),
    .o_carryup(min_carry), .o_borrowdown(min_borrow), .o_event(min_event), .o_load_err(min_err)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counting rules written as plain arithmetic.
  function automatic int modelNext(int modulo, bit sat, int c, bit load, int lv, bit up, bit down);
    if (load) return (lv < modulo) ? lv : modulo - 1;
    if (up && down) return 0;
    if (up) return sat ? ((c + 1 > modulo - 1) ? modulo - 1 : c + 1) : (c + 1) % modulo;
    if (down) return sat ? ((c - 1 < 0) ? 0 : c - 1) : (c + modulo - 1) % modulo;
    return c;
  endfunction

  function automatic bit modelCarry(int modulo, int c, bit load, bit up, bit down);
    return up && !down && !load && (c == modulo - 1);
  endfunction

  function automatic bit modelBorrow(int c, bit load, bit up, bit down);
    return down && !up && !load && (c == 0);
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic compareState(input string tag);
    checkOutput({tag, " a_count"},   int'(a_count),   ma_count);
    checkOutput({tag, " a_event"},   int'(a_event),   int'(ma_event));
    checkOutput({tag, " a_err"},     int'(a_err),     int'(ma_err));
    checkOutput({tag, " s_count"},   int'(s_count),   ms_count);
    checkOutput({tag, " s_event"},   int'(s_event),   int'(ms_event));
    checkOutput({tag, " s_err"},     int'(s_err),     int'(ms_err));
    checkOutput({tag, " sec_count"}, int'(sec_count), mc_count);
    checkOutput({tag, " sec_event"}, int'(sec_event), int'(mc_event));
    checkOutput({tag, " sec_err"},   int'(sec_err),   int'(mc_err));
    checkOutput({tag, " min_count"}, int'(min_count), mm_count);
    checkOutput({tag, " min_event"}, int'(min_event), int'(mm_event));
    checkOutput({tag, " min_err"},   int'(min_err),   int'(mm_err));
  endtask

  task automatic resetModels();
    ma_count = 0; ms_count = 0; mc_count = 0; mm_count = 0;
    ma_event = 0; ma_err = 0; ms_event = 0; ms_err = 0;
    mc_event = 0; mc_err = 0; mm_event = 0; mm_err = 0;
  endtask

  task automatic idleInputs();
    a_up = 0; a_down = 0; a_load = 0; a_clr = 0; a_lv = '0;
    s_up = 0; s_down = 0; s_load = 0; s_clr = 0; s_lv = '0;
    sec_up = 0; sec_down = 0; sec_load = 0; sec_clr = 0; sec_lv = '0;
    min_down = 0; min_load = 0; min_clr = 0; min_lv = '0;
  endtask

  // Called just after a falling edge with inputs already set up.
  task automatic stepCycle();
    bit ca, ba, cs, bs, cc, bc, cm, bm;
    #1;
    ca = modelCarry(1000, ma_count, a_load, a_up, a_down);
    ba = modelBorrow(ma_count, a_load, a_up, a_down);
    cs = modelCarry(60, ms_count, s_load, s_up, s_down);
    bs = modelBorrow(ms_count, s_load, s_up, s_down);
    cc = modelCarry(60, mc_count, sec_load, sec_up, sec_down);
    bc = modelBorrow(mc_count, sec_load, sec_up, sec_down);
    cm = modelCarry(60, mm_count, min_load, cc, min_down);
    bm = modelBorrow(mm_count, min_load, cc, min_down);
    checkOutput("a_carry",    int'(a_carry),    int'(ca));
    checkOutput("a_borrow",   int'(a_borrow),   int'(ba));
    checkOutput("s_carry",    int'(s_carry),    int'(cs));
    checkOutput("s_borrow",   int'(s_borrow),   int'(bs));
    checkOutput("sec_carry",  int'(sec_carry),  int'(cc));
    checkOutput("sec_borrow", int'(sec_borrow), int'(bc));
    checkOutput("min_carry",  int'(min_carry),  int'(cm));
    checkOutput("min_borrow", int'(min_borrow), int'(bm));
    @(posedge clk);
    ma_event = (ma_event && !a_clr) || ca || ba;
    ma_err   = (ma_err && !a_clr) || (a_load && a_lv >= 1000);
    ma_count = modelNext(1000, 0, ma_count, a_load, int'(a_lv), a_up, a_down);
    ms_event = (ms_event && !s_clr) || cs || bs;
    ms_err   = (ms_err && !s_clr) || (s_load && s_lv >= 60);
    ms_count = modelNext(60, 1, ms_count, s_load, int'(s_lv), s_up, s_down);
    mc_event = (mc_event && !sec_clr) || cc || bc;
    mc_err   = (mc_err && !sec_clr) || (sec_load && sec_lv >= 60);
    mc_count = modelNext(60, 0, mc_count, sec_load, int'(sec_lv), sec_up, sec_down);
    mm_event = (mm_event && !min_clr) || cm || bm;
    mm_err   = (mm_err && !min_clr) || (min_load && min_lv >= 60);
    mm_count = modelNext(60, 0, mm_count, min_load, int'(min_lv), cc, min_down);
    #1;
    compareState("edge");
    @(negedge clk);
  endtask

  // Called just after a falling edge; leaves reset released one edge later.
  task automatic applyReset();
    idleInputs();
    rstn = 1'b0;
    #1;
    resetModels();
    compareState("reset");
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic applyStimulus();
    a_up = 1'($urandom); a_down = 1'($urandom);
    a_load = ($urandom_range(0, 7) == 0); a_clr = ($urandom_range(0, 7) == 0);
    a_lv = 10'($urandom_range(0, 1023));
    s_up = 1'($urandom); s_down = 1'($urandom);
    s_load = ($urandom_range(0, 7) == 0); s_clr = ($urandom_range(0, 7) == 0);
    s_lv = 6'($urandom_range(0, 63));
    sec_up = ($urandom_range(0, 3) != 0); sec_down = ($urandom_range(0, 5) == 0);
    sec_load = ($urandom_range(0, 9) == 0); sec_clr = ($urandom_range(0, 7) == 0);
    sec_lv = 6'($urandom_range(0, 63));
    min_down = ($urandom_range(0, 7) == 0);
    min_load = ($urandom_range(0, 9) == 0); min_clr = ($urandom_range(0, 7) == 0);
    min_lv = 6'($urandom_range(0, 63));
  endtask

  // Directed scenarios, a random phase and a mid-cycle reset.
  initial begin
    rstn = 1'b0;
    idleInputs();
    resetModels();
    @(negedge clk);
    applyReset();

    $display("[TB] full up-count wrap");
    a_up = 1;
    repeat (1001) stepCycle();
    checkOutput("t1 count", int'(a_count), 1);
    checkOutput("t1 event", int'(a_event), 1);

    $display("[TB] down-count from reset and flag clear");
    applyReset();
    a_down = 1;
    stepCycle();
    checkOutput("t2 first", int'(a_count), 999);
    stepCycle();
    checkOutput("t2 second", int'(a_count), 998);
    a_down = 0; a_clr = 1;
    stepCycle();
    a_clr = 0;
    checkOutput("t2 cleared", int'(a_event), 0);

    $display("[TB] saturate at both ends");
    s_load = 1; s_lv = 6'd59;
    stepCycle();
    s_load = 0; s_up = 1;
    repeat (3) stepCycle();
    checkOutput("t3 held top", int'(s_count), 59);
    s_up = 0; s_load = 1; s_lv = 6'd0;
    stepCycle();
    s_load = 0; s_down = 1;
    stepCycle();
    s_down = 0;
    checkOutput("t3 held bottom", int'(s_count), 0);

    $display("[TB] load clamp and priority");
    a_load = 1; a_lv = 10'd1023;
    stepCycle();
    checkOutput("t4 clamp", int'(a_count), 999);
    checkOutput("t4 load_err", int'(a_err), 1);
    a_up = 1; a_lv = 10'd5;
    stepCycle();
    checkOutput("t4 load wins", int'(a_count), 5);
    a_up = 0; a_lv = 10'd500;
    stepCycle();
    a_load = 0; a_up = 1; a_down = 1;
    stepCycle();
    checkOutput("t4 sync clear", int'(a_count), 0);
    a_up = 0; a_down = 0;

    $display("[TB] sec to min chain");
    sec_load = 1; sec_lv = 6'd59; min_load = 1; min_lv = 6'd59;
    stepCycle();
    sec_load = 0; min_load = 0; sec_up = 1;
    stepCycle();
    sec_up = 0;
    checkOutput("t5 sec", int'(sec_count), 0);
    checkOutput("t5 min", int'(min_count), 0);
    checkOutput("t5 min event", int'(min_event), 1);

    $display("[TB] random traffic");
    repeat (400) begin
      applyStimulus();
      stepCycle();
    end

    $display("[TB] reset between edges");
    idleInputs();
    a_up = 1;
    repeat (5) stepCycle();
    #2;
    rstn = 1'b0;
    #1;
    resetModels();
    compareState("async");
    @(negedge clk);
    rstn = 1'b1;
    stepCycle();
    checkOutput("t6 restart", int'(a_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
